// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues reads to a one-cycle-latency
// synchronous instruction memory and presents one instruction per cycle to
// the IF/ID register. It has a one-entry skid buffer for stalls, squashes on
// redirect, and stops fetching after a HALT opcode is consumed.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               halted
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0]  rsp_pc_q, rsp_pc_d;
  logic               hold_valid_q, hold_valid_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;
  logic               halted_q, halted_d;

  logic               issue;
  logic               consume;
  logic               take_halt;
  logic [INSTR_W-1:0] sel_instr;
  logic [ADDR_W-1:0]  sel_pc;

  // Issue, output select and next-state computation.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block
    // can leave a value unassigned and infer a latch.
    pc_d         = pc_q;
    rsp_valid_d  = 1'b0;
    rsp_pc_d     = rsp_pc_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    halted_d     = halted_q;

    // Reads are suppressed while reset is asserted so the reset cycle shows
    // no request regardless of what the state held before.
    issue     = rst_n && !halted_q && (redirect || !stall);
    imem_en   = issue;
    imem_addr = redirect ? redirect_pc : pc_q;

    // The hold entry is older than any live response, so it is shown first.
    sel_instr   = hold_valid_q ? hold_instr_q : imem_data;
    sel_pc      = hold_valid_q ? hold_pc_q    : rsp_pc_q;
    instr_valid = rst_n && (hold_valid_q || rsp_valid_q) && !redirect;
    instruction = instr_valid ? sel_instr : '0;
    instr_pc    = instr_valid ? sel_pc    : '0;
    halted      = rst_n && halted_q;

    consume   = instr_valid && !stall;
    take_halt = consume && (sel_instr[INSTR_W-1 -: 4] == HALT_OP);

    if (issue) begin
      pc_d        = imem_addr + ADDR_W'(1);
      rsp_valid_d = 1'b1;
      rsp_pc_d    = imem_addr;
    end

    // Redirect discards everything older than the target fetch.
    if (redirect) begin
      hold_valid_d = 1'b0;
    end else if (hold_valid_q && !stall) begin
      hold_valid_d = 1'b0;
    end else if (rsp_valid_q && stall && !hold_valid_q) begin
      // The memory only drives this data for one cycle, so park it.
      hold_valid_d = 1'b1;
      hold_instr_d = imem_data;
      hold_pc_d    = rsp_pc_q;
    end

    // HALT is delivered, but the read issued alongside it must never appear.
    if (take_halt) begin
      halted_d    = 1'b1;
      rsp_valid_d = 1'b0;
    end
  end

  // Control state: synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values and the result does not depend on order.
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      rsp_valid_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      rsp_valid_q  <= rsp_valid_d;
      hold_valid_q <= hold_valid_d;
      halted_q     <= halted_d;
    end
  end

  // Payload registers: qualified by their valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    // NOTE: data-only registers skip reset; their valid flags are reset and
    // the outputs are forced to zero whenever nothing valid is shown.
    rsp_pc_q     <= rsp_pc_d;
    hold_instr_q <= hold_instr_d;
    hold_pc_q    <= hold_pc_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (RESET_PC 0000 and FFFE),
// each with a one-cycle-latency memory model returning addr + 16'h1000.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance 0: main scenarios.
  logic        rst_n, stall, redirect;
  logic [15:0] redirect_pc;
  logic        imem_en;
  logic [15:0] imem_addr, imem_data, instruction, instr_pc;
  logic        instr_valid, halted;
  logic        halt_en;

  // Instance 1: wrap scenario.
  logic        rst_n1;
  logic        imem_en1;
  logic [15:0] imem_addr1, imem_data1, instruction1, instr_pc1;
  logic        instr_valid1, halted1;

  fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .HALT_OP(4'hF)) dut0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .instruction(instruction), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .halted(halted)
  );

  fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'hFFFE), .HALT_OP(4'hF)) dut1 (
    .clk(clk), .rst_n(rst_n1), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(16'h0000), .imem_en(imem_en1), .imem_addr(imem_addr1),
    .imem_data(imem_data1), .instruction(instruction1), .instr_pc(instr_pc1),
    .instr_valid(instr_valid1), .halted(halted1)
  );

  // Synchronous instruction memory models, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_data <= (halt_en && imem_addr == 16'h0003) ? 16'hF000
                                                                 : imem_addr + 16'h1000;
    if (imem_en1) imem_data1 <= imem_addr1 + 16'h1000;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] ins,
                         input logic [15:0] pc);
    check({tag, ".valid"}, 32'(instr_valid), 32'(v));
    check({tag, ".instr"}, 32'(instruction), 32'(ins));
    check({tag, ".pc"},    32'(instr_pc),    32'(pc));
  endtask

  task automatic chk_issue(input string tag, input logic en, input logic [15:0] addr);
    check({tag, ".en"}, 32'(imem_en), 32'(en));
    if (en) check({tag, ".addr"}, 32'(imem_addr), 32'(addr));
  endtask

  task automatic chk_out1(input string tag, input logic v, input logic [15:0] ins,
                          input logic [15:0] pc);
    check({tag, ".valid"}, 32'(instr_valid1), 32'(v));
    check({tag, ".instr"}, 32'(instruction1), 32'(ins));
    check({tag, ".pc"},    32'(instr_pc1),    32'(pc));
  endtask

  // Advance to the next cycle's drive point (just after the falling edge).
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rst_n1 = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 16'h0000; halt_en = 1'b0;

    // Reset cycle outputs.
    cyc(); settle();
    chk_out("rst", 1'b0, 16'h0000, 16'h0000);
    chk_issue("rst", 1'b0, 16'h0000);
    check("rst.halted", 32'(halted), 32'd0);
    cyc(); settle();

    // Reset release: one bubble, then sequential stream.
    cyc(); rst_n = 1'b1; settle();
    chk_out("rel", 1'b0, 16'h0000, 16'h0000);
    chk_issue("rel", 1'b1, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      cyc(); settle();
      chk_out($sformatf("seq%0d", i), 1'b1, 16'h1000 + 16'(i), 16'(i));
      chk_issue($sformatf("seq%0d", i), 1'b1, 16'(i + 1));
    end

    // Stall 3 cycles while pc 5 is shown.
    for (int i = 0; i < 3; i++) begin
      cyc(); stall = 1'b1; settle();
      chk_out($sformatf("stl%0d", i), 1'b1, 16'h1005, 16'h0005);
      chk_issue($sformatf("stl%0d", i), 1'b0, 16'h0000);
    end
    cyc(); stall = 1'b0; settle();
    chk_out("stl_rel", 1'b1, 16'h1005, 16'h0005);
    chk_issue("stl_rel", 1'b1, 16'h0006);
    cyc(); settle();
    chk_out("stl_nxt", 1'b1, 16'h1006, 16'h0006);

    // Redirect to 0040 while pc 7 is shown.
    cyc(); redirect = 1'b1; redirect_pc = 16'h0040; settle();
    chk_out("rdr", 1'b0, 16'h0000, 16'h0000);
    chk_issue("rdr", 1'b1, 16'h0040);
    cyc(); redirect = 1'b0; settle();
    chk_out("rdr_tgt", 1'b1, 16'h1040, 16'h0040);
    cyc(); settle();
    chk_out("rdr_nxt", 1'b1, 16'h1041, 16'h0041);

    // Redirect together with stall and a full hold entry (pc 42 held).
    cyc(); stall = 1'b1; settle();
    chk_out("rs_show", 1'b1, 16'h1042, 16'h0042);
    cyc(); settle();
    chk_out("rs_hold", 1'b1, 16'h1042, 16'h0042);
    cyc(); redirect = 1'b1; redirect_pc = 16'h0080; settle();
    chk_out("rs_rdr", 1'b0, 16'h0000, 16'h0000);
    chk_issue("rs_rdr", 1'b1, 16'h0080);
    cyc(); redirect = 1'b0; stall = 1'b0; settle();
    chk_out("rs_tgt", 1'b1, 16'h1080, 16'h0080);
    cyc(); settle();
    chk_out("rs_nxt", 1'b1, 16'h1081, 16'h0081);

    // HALT at address 3.
    halt_en = 1'b1;
    cyc(); redirect = 1'b1; redirect_pc = 16'h0000; settle();
    chk_issue("h_rdr", 1'b1, 16'h0000);
    cyc(); redirect = 1'b0; settle();
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("h_seq%0d", i), 1'b1, 16'h1000 + 16'(i), 16'(i));
      cyc(); settle();
    end
    chk_out("h_op", 1'b1, 16'hF000, 16'h0003);
    check("h_op.halted", 32'(halted), 32'd0);
    cyc(); settle();
    check("h_after.halted", 32'(halted), 32'd1);
    chk_out("h_after", 1'b0, 16'h0000, 16'h0000);
    chk_issue("h_after", 1'b0, 16'h0000);
    cyc(); redirect = 1'b1; redirect_pc = 16'h0010; settle();
    chk_issue("h_rdr_ign", 1'b0, 16'h0000);
    chk_out("h_rdr_ign", 1'b0, 16'h0000, 16'h0000);
    cyc(); redirect = 1'b0; settle();
    chk_out("h_still", 1'b0, 16'h0000, 16'h0000);
    check("h_still.halted", 32'(halted), 32'd1);
    halt_en = 1'b0;

    // Reset clears halted and restarts at RESET_PC.
    cyc(); rst_n = 1'b0; settle();
    check("h_rst.halted", 32'(halted), 32'd0);
    chk_issue("h_rst", 1'b0, 16'h0000);
    cyc(); rst_n = 1'b1; settle();
    chk_issue("h_rel", 1'b1, 16'h0000);
    check("h_rel.halted", 32'(halted), 32'd0);
    cyc(); settle();
    chk_out("h_rel0", 1'b1, 16'h1000, 16'h0000);

    // PC wrap on the RESET_PC=FFFE instance.
    cyc(); rst_n1 = 1'b1; settle();
    check("w_rel.en", 32'(imem_en1), 32'd1);
    check("w_rel.addr", 32'(imem_addr1), 32'hFFFE);
    chk_out1("w_rel", 1'b0, 16'h0000, 16'h0000);
    cyc(); settle();
    chk_out1("w0", 1'b1, 16'h0FFE, 16'hFFFE);
    cyc(); settle();
    chk_out1("w1", 1'b1, 16'h0FFF, 16'hFFFF);
    check("w1.addr", 32'(imem_addr1), 32'h0000);
    cyc(); settle();
    chk_out1("w2", 1'b1, 16'h1000, 16'h0000);
    cyc(); settle();
    chk_out1("w3", 1'b1, 16'h1001, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the IF/ID pipeline register. Holds the program counter and issues word-addressed reads to a synchronous instruction memory with one-cycle read latency. Presents one instruction per cycle with its PC and a valid flag to the IF/ID register. Handles stall back-pressure without losing an in-flight read, branch redirect with squash, and halting on a HALT opcode.

## Interface

- ADDR_W, 16, PC / instruction-memory address width (word addressed)
- INSTR_W, 16, instruction width
- RESET_PC, 16'h0000, first fetch address after reset
- HALT_OP, 4'hF, opcode in instruction[15:12] that halts fetch
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  IF/ID not accepting this cycle (hazard unit)
- redirect  in  1  taken branch/jump resolved downstream this cycle
- redirect_pc  in  ADDR_W  target address, valid when redirect=1
- imem_en  out  1  read request this cycle
- imem_addr  out  ADDR_W  read address
- imem_data  in  INSTR_W  read data for request issued previous cycle
- instruction  out  INSTR_W  instruction to IF/ID register
- instr_pc  out  ADDR_W  address of instruction
- instr_valid  out  1  instruction/instr_pc meaningful
- halted  out  1  fetch stopped by HALT

## Operation

- State: pc (next sequential address), rsp_valid/rsp_pc (read issued last cycle, not squashed), hold_valid/hold_instr/hold_pc (one-entry skid), halted.
- Issue: imem_en = !halted & (redirect | !stall); imem_addr = redirect ? redirect_pc : pc. Combinational.
- On issue: pc <= imem_addr + 1 (wraps FFFF -> 0000); rsp_valid <= 1; rsp_pc <= imem_addr. Without issue: rsp_valid <= 0, pc unchanged.
- Output select: hold_valid ? hold entry : imem_data/rsp_pc. instr_valid = (hold_valid | rsp_valid) & !redirect. When instr_valid=0, instruction = 16'h0000 (NOP), instr_pc = 0.
- Consume: instr_valid & !stall. Hold entry consumed -> hold_valid <= 0.
- Skid: rsp_valid & stall & !hold_valid & !redirect -> capture imem_data/rsp_pc into hold, hold_valid <= 1. rsp_valid and hold_valid are never both 1 at output (no issue while stalled).
- Redirect (priority over stall and hold): hold_valid <= 0; in-flight response discarded; read at redirect_pc issued same cycle; target instruction appears next cycle.
- Halt: consuming an instruction with [15:12]==HALT_OP sets halted <= 1 and squashes the read issued that cycle (rsp_valid <= 0). HALT itself is delivered. halted clears only on reset; redirect ignored once halted.

## Timing

- Reset (rst_n=0 at edge): pc=RESET_PC, rsp_valid=0, hold_valid=0, halted=0. During reset cycle outputs: imem_en=0, instr_valid=0, instruction=0, instr_pc=0, halted=0.
- First cycle after reset: imem_en=1, imem_addr=RESET_PC; instruction valid the following cycle (latency 1).
- Steady state: one instruction per cycle, no bubbles.
- Stall asserted at cycle t: instruction shown at t held (skid) and reshown every stalled cycle; no issue during t..; release at u: held instruction consumed at u and read issued at u, so next instruction at u+1 — zero bubbles.
- Redirect at t: instr_valid=0 at t, target valid at t+1; exactly one bubble.
- Redirect and stall together: redirect wins; fetch issued.
- Reset mid-stall or mid-redirect: all state cleared as above; pending data discarded.
- PC wrap: read at FFFF followed by read at 0000.

## Test plan

- Reset release, imem returns mem[a]=a+16'h1000, no stall -> instr_valid low 1 cycle, then instruction 1000,1001,1002 with instr_pc 0,1,2 on consecutive cycles.
- stall high 3 cycles while instr_pc=5 shown -> instruction/instr_pc=5 held all 3 cycles, imem_en=0; after release 5 consumed, 6 next cycle, no duplicate or drop.
- redirect with redirect_pc=16'h0040 while instr_pc=7 shown -> instr_valid=0 that cycle, imem_addr=0040, next cycle instr_pc=0040; 7's successor never delivered.
- redirect concurrent with stall and full hold entry -> hold discarded, target delivered next cycle.
- mem[3]=16'hF000 -> instruction at pc 3 delivered, halted=1 next cycle, imem_en=0 and instr_valid=0 thereafter; redirect ignored; rst_n low clears halted and restarts at RESET_PC.
- RESET_PC=16'hFFFE -> instr_pc sequence FFFE, FFFF, 0000, 0001.
